// File: rtl/udp_img_pkg.sv
// Shared definitions for the image-stream UDP transmit scheduler.
package udp_img_pkg;

    localparam logic [15:0] HDR_MAGIC = 16'hA55A;
    localparam int unsigned HDR_WORDS = 2;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        WAIT_DATA,
        START,
        SEND,
        WAIT_DONE,
        GAP
    } state_t;

    function automatic logic [15:0] pkt_byte_num(input int unsigned pkt_words);
        return 16'((pkt_words + HDR_WORDS) * 4);
    endfunction

endpackage

// File: rtl/udp_img_hdr_mux.sv
// Registered tx_data source: two header words, then PKT_WORDS FIFO words per packet.
module udp_img_hdr_mux
    import udp_img_pkg::*;
#(
    parameter int unsigned PKT_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        send,
    input  logic        tx_req,
    input  logic [15:0] frame_cnt,
    input  logic [15:0] pkt_idx,
    input  logic [31:0] fifo_dout,
    output logic [31:0] tx_data,
    output logic        fifo_rd_en,
    output logic        last_word
);

    localparam int unsigned LAST_IDX = PKT_WORDS + HDR_WORDS - 1;

    logic [15:0] word_cnt;
    logic [31:0] next_word;

    always_comb begin
        fifo_rd_en = send && tx_req && (word_cnt >= 16'(HDR_WORDS));
        last_word  = send && tx_req && (word_cnt == 16'(LAST_IDX));
        next_word  = '0;
        // Requests outside SEND (e.g. a surplus one after the last word) load zero.
        if (send) begin
            case (word_cnt)
                16'd0:   next_word = {HDR_MAGIC, frame_cnt};
                16'd1:   next_word = {pkt_idx, 16'(PKT_WORDS)};
                default: next_word = fifo_dout;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt <= '0;
            tx_data  <= '0;
        end else begin
            if (clr) begin
                word_cnt <= '0;
            end else if (send && tx_req) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (tx_req) begin
                tx_data <= next_word;
            end
        end
    end

endmodule

// File: rtl/udp_img_tx_sched.sv
// Slices buffered video frames into fixed-size UDP packets and paces them into udp_top.
module udp_img_tx_sched
    import udp_img_pkg::*;
#(
    parameter int unsigned PKT_WORDS      = 256,
    parameter int unsigned PKTS_PER_FRAME = 600,
    parameter int unsigned IFG_CYCLES     = 64,
    parameter int unsigned TIMEOUT_CYCLES = 1048576,
    parameter int unsigned FIFO_CNT_W     = 12
) (
    input  logic                  gmii_tx_clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic                  frame_start,
    input  logic [FIFO_CNT_W-1:0] fifo_rd_cnt,
    input  logic [31:0]           fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx_start_en,
    output logic [15:0]           tx_byte_num,
    output logic [31:0]           tx_data,
    input  logic                  tx_req,
    input  logic                  udp_tx_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_cnt,
    output logic                  timeout_err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(IFG_CYCLES + 1);

    state_t           state, next_state;
    logic [15:0]      pkt_idx;
    logic             last;
    logic [TO_W-1:0]  to_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_word;
    logic             pkt_last;
    logic             to_hit;
    logic             gap_end;
    logic             data_ready;

    assign tx_byte_num = pkt_byte_num(PKT_WORDS);
    assign tx_start_en = (state == START);
    assign busy        = !(state == IDLE || state == WAIT_FRAME);
    assign pkt_last    = (pkt_idx == 16'(PKTS_PER_FRAME - 1));
    assign to_hit      = (state == WAIT_DONE) && !udp_tx_done && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign gap_end     = (gap_cnt == GAP_W'(IFG_CYCLES - 1));
    assign data_ready  = (32'(fifo_rd_cnt) >= PKT_WORDS);

    udp_img_hdr_mux #(
        .PKT_WORDS (PKT_WORDS)
    ) u_hdr_mux (
        .clk        (gmii_tx_clk),
        .rst        (rst),
        .clr        (state == START),
        .send       (state == SEND),
        .tx_req     (tx_req),
        .frame_cnt  (frame_cnt),
        .pkt_idx    (pkt_idx),
        .fifo_dout  (fifo_dout),
        .tx_data    (tx_data),
        .fifo_rd_en (fifo_rd_en),
        .last_word  (last_word)
    );

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:       if (enable) next_state = WAIT_FRAME;
            WAIT_FRAME: begin
                if (!enable)         next_state = IDLE;
                else if (frame_start) next_state = WAIT_DATA;
            end
            WAIT_DATA:  if (data_ready) next_state = START;
            START:      next_state = SEND;
            SEND:       if (last_word) next_state = WAIT_DONE;
            WAIT_DONE:  if (udp_tx_done || to_hit) next_state = GAP;
            GAP: begin
                // A disabled stream abandons the frame only once the packet in flight is done.
                if (gap_end) begin
                    if (!enable)   next_state = IDLE;
                    else if (last) next_state = WAIT_FRAME;
                    else           next_state = WAIT_DATA;
                end
            end
            default:    next_state = IDLE;
        endcase
    end

    always_ff @(posedge gmii_tx_clk or posedge rst) begin
        if (rst) begin
            pkt_idx     <= '0;
            frame_cnt   <= '0;
            last        <= 1'b0;
            to_cnt      <= '0;
            gap_cnt     <= '0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
            to_cnt      <= (state == WAIT_DONE) ? to_cnt + TO_W'(1) : '0;
            gap_cnt     <= (state == GAP) ? gap_cnt + GAP_W'(1) : '0;
            case (state)
                WAIT_FRAME: if (enable && frame_start) pkt_idx <= '0;
                WAIT_DONE: begin
                    if (udp_tx_done) begin
                        if (pkt_last) begin
                            pkt_idx    <= '0;
                            frame_cnt  <= frame_cnt + 16'd1;
                            frame_done <= 1'b1;
                            last       <= 1'b1;
                        end else begin
                            pkt_idx <= pkt_idx + 16'd1;
                            last    <= 1'b0;
                        end
                    end else if (to_hit) begin
                        timeout_err <= 1'b1;
                        pkt_idx     <= '0;
                        last        <= 1'b1;
                    end
                end
                GAP:        if (gap_end && !enable) pkt_idx <= '0;
                default:    ;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_img_tx_sched.sv
// Randomized self-checking bench: FIFO + udp_top stand-ins against a packet-level model.
module tb_udp_img_tx_sched;

    localparam int unsigned PW  = 4;
    localparam int unsigned PPF = 2;
    localparam int unsigned IFG = 8;
    localparam int unsigned TMO = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        frame_start;
    logic [11:0] fifo_rd_cnt;
    logic [31:0] fifo_dout;
    logic        fifo_rd_en;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        tx_req;
    logic        udp_tx_done;
    logic        busy;
    logic        frame_done;
    logic [15:0] frame_cnt;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;

    // Upstream FIFO stand-in and its expected-content queue
    logic [31:0] mem [64];
    int          rd_ptr = 0;
    int          wr_ptr = 0;
    logic        hold   = 1'b0;
    logic [11:0] forced = '0;
    logic [31:0] exp_q [$];

    // Event counters
    int pops = 0, starts = 0, dones = 0, touts = 0;

    // Packet-level reference state
    logic [15:0] m_frame = '0;
    logic [15:0] m_pkt   = '0;

    always #5 clk = ~clk;

    assign fifo_dout   = mem[rd_ptr[5:0]];
    assign fifo_rd_cnt = hold ? forced : 12'(wr_ptr - rd_ptr);

    udp_img_tx_sched #(
        .PKT_WORDS      (PW),
        .PKTS_PER_FRAME (PPF),
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO),
        .FIFO_CNT_W     (12)
    ) dut (
        .gmii_tx_clk (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_start (frame_start),
        .fifo_rd_cnt (fifo_rd_cnt),
        .fifo_dout   (fifo_dout),
        .fifo_rd_en  (fifo_rd_en),
        .tx_start_en (tx_start_en),
        .tx_byte_num (tx_byte_num),
        .tx_data     (tx_data),
        .tx_req      (tx_req),
        .udp_tx_done (udp_tx_done),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt),
        .timeout_err (timeout_err)
    );

    always @(posedge clk) begin
        if (rst) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (fifo_rd_en) begin
                rd_ptr <= rd_ptr + 1;
                pops   <= pops + 1;
            end
            if (tx_start_en) starts <= starts + 1;
            if (frame_done)  dones  <= dones + 1;
            if (timeout_err) touts  <= touts + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [31:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr++;
        exp_q.push_back(v);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_pkt = '0;
    endtask

    task automatic idle_gap();
        repeat (IFG + 4) tick();
    endtask

    task automatic wait_start(output int w);
        w = 0;
        while (!tx_start_en && w < 300) begin
            tick();
            w++;
        end
        check_eq("start seen", 32'(tx_start_en), 32'd1);
    endtask

    // Acts as udp_top for one packet and checks every word it carries.
    task automatic serve(input bit drop_en, input bit extra, input bit do_done, output int w);
        logic [31:0] exp_w [PW+2];
        int p0;
        wait_start(w);
        exp_w[0] = {16'hA55A, m_frame};
        exp_w[1] = {m_pkt, 16'(PW)};
        for (int i = 2; i < PW + 2; i++)
            exp_w[i] = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hBAD0BAD0;
        if (drop_en) enable = 1'b0;
        p0 = pops;
        repeat ($urandom_range(1, 3)) tick();
        for (int i = 0; i < PW + 2; i++) begin
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            check_eq($sformatf("pkt%0d word%0d", m_pkt, i), tx_data, exp_w[i]);
            if (i < PW + 1) repeat ($urandom_range(0, 2)) tick();
        end
        check_eq("pops per pkt", 32'(pops - p0), 32'(PW));
        if (extra) begin
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
            check_eq("extra req data", tx_data, 32'd0);
            check_eq("extra req pops", 32'(pops - p0), 32'(PW));
        end
        if (do_done) begin
            repeat ($urandom_range(0, 4)) tick();
            udp_tx_done = 1'b1;
            tick();
            udp_tx_done = 1'b0;
            m_pkt++;
            if (m_pkt == 16'(PPF)) begin
                m_pkt = '0;
                m_frame++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, s0;
        rst = 1'b1; enable = 1'b0; frame_start = 1'b0;
        tx_req = 1'b0; udp_tx_done = 1'b0;
        tick(); tick();
        check_eq("rst tx_start_en", 32'(tx_start_en), 32'd0);
        check_eq("rst fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("rst tx_data", tx_data, 32'd0);
        check_eq("rst busy", 32'(busy), 32'd0);
        check_eq("rst frame_cnt", 32'(frame_cnt), 32'd0);
        check_eq("rst frame_done", 32'(frame_done), 32'd0);
        check_eq("rst timeout_err", 32'(timeout_err), 32'd0);
        check_eq("tx_byte_num", 32'(tx_byte_num), 32'd24);
        rst = 1'b0;
        enable = 1'b1;
        tick(); tick();

        // Full frame with payload 1..8
        for (int i = 1; i <= 8; i++) push(32'(i));
        start_frame();
        serve(0, 0, 1, w);
        check_eq("no frame_done mid frame", 32'(dones), 32'd0);
        serve(0, 1, 1, w);
        check_eq("gap after done", 32'(w >= int'(IFG + 1)), 32'd1);
        idle_gap();
        check_eq("frame1 starts", 32'(starts), 32'd2);
        check_eq("frame1 frame_done", 32'(dones), 32'd1);
        check_eq("frame1 frame_cnt", 32'(frame_cnt), 32'(m_frame));
        check_eq("frame1 idle busy", 32'(busy), 32'd0);

        // Start threshold: count one short of a packet must hold off
        hold = 1'b1; forced = 12'(PW - 1);
        for (int i = 0; i < 8; i++) push($urandom);
        s0 = starts;
        start_frame();
        repeat (20) tick();
        check_eq("below threshold starts", 32'(starts - s0), 32'd0);
        forced = 12'(PW);
        serve(0, 0, 1, w);
        check_eq("threshold start latency", 32'(w <= 2), 32'd1);
        hold = 1'b0;
        serve(0, 0, 1, w);
        idle_gap();
        check_eq("frame2 frame_cnt", 32'(frame_cnt), 32'(m_frame));

        // Withheld udp_tx_done
        for (int i = 0; i < 4; i++) push($urandom);
        s0 = dones;
        start_frame();
        serve(0, 0, 0, w);
        w = 0;
        while (!timeout_err && w < 300) begin
            tick();
            w++;
        end
        check_eq("timeout latency", 32'(w), 32'(TMO));
        idle_gap();
        check_eq("timeout count", 32'(touts), 32'd1);
        check_eq("timeout back to wait_frame", 32'(busy), 32'd0);
        check_eq("timeout frame_cnt", 32'(frame_cnt), 32'(m_frame));
        check_eq("timeout no frame_done", 32'(dones - s0), 32'd0);

        // enable dropped during packet 0; remaining words stay in the FIFO
        for (int i = 0; i < 8; i++) push($urandom);
        s0 = starts;
        start_frame();
        serve(1, 0, 1, w);
        repeat (IFG + 20) tick();
        check_eq("drop single start", 32'(starts - s0), 32'd1);
        check_eq("drop busy", 32'(busy), 32'd0);
        check_eq("drop frame_cnt", 32'(frame_cnt), 32'(m_frame));
        enable = 1'b1;
        tick(); tick();

        // Asynchronous reset in the middle of a payload word
        for (int i = 0; i < 4; i++) push($urandom);
        start_frame();
        wait_start(w);
        tick();
        for (int i = 0; i < 3; i++) begin
            tx_req = 1'b1;
            tick();
            tx_req = 1'b0;
        end
        check_eq("pre-rst payload", tx_data, exp_q[0]);
        tx_req = 1'b1;
        #3 rst = 1'b1;
        #1;
        check_eq("async rst fifo_rd_en", 32'(fifo_rd_en), 32'd0);
        check_eq("async rst tx_data", tx_data, 32'd0);
        check_eq("async rst busy", 32'(busy), 32'd0);
        check_eq("async rst frame_cnt", 32'(frame_cnt), 32'd0);
        tick();
        tx_req = 1'b0;
        rst = 1'b0;
        exp_q.delete();
        m_frame = '0;
        m_pkt = '0;
        tick(); tick();
        for (int i = 0; i < 8; i++) push($urandom);
        start_frame();
        serve(0, 0, 1, w);
        serve(0, 0, 1, w);
        idle_gap();
        check_eq("post-rst frame_cnt", 32'(frame_cnt), 32'(m_frame));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/udp_img_tx_sched.md
Name: udp_img_tx_sched

Overview:
Packet scheduler that sequences the UDP transmit path for image streaming. It slices each video frame, buffered as 32-bit words in an upstream FWFT FIFO, into fixed-size UDP packets and prepends a 2-word header to each packet. It drives tx_start_en, tx_byte_num and tx_data into udp_top, serves tx_req, waits for tx_done and enforces an inter-packet gap. It sits between the image FIFO read side and udp_top, all in the GMII tx clock domain.

Parameters:
PKT_WORDS, 256, payload words per packet (1..16381).
PKTS_PER_FRAME, 600, packets per frame (1..65535).
IFG_CYCLES, 64, idle cycles after tx_done before the next tx_start_en (>=1).
TIMEOUT_CYCLES, 1048576, maximum cycles in WAIT_DONE before abort.
FIFO_CNT_W, 12, width of fifo_rd_cnt.

Ports:
gmii_tx_clk  in  1  sole clock.
rst  in  1  asynchronous active-high reset.
enable  in  1  level; 1 = streaming allowed.
frame_start  in  1  pulse marking the first word of a new frame entering the FIFO.
fifo_rd_cnt  in  FIFO_CNT_W  words available in the FIFO.
fifo_dout  in  32  FWFT head word.
fifo_rd_en  out  1  pop FIFO head.
tx_start_en  out  1  one-cycle start pulse to udp_top.
tx_byte_num  out  16  packet byte count, constant (2+PKT_WORDS)*4.
tx_data  out  32  word to udp_top.
tx_req  in  1  udp_top data request; word is sampled the cycle after tx_req.
udp_tx_done  in  1  one-cycle pulse at end of packet.
busy  out  1  high in any state except IDLE and WAIT_FRAME.
frame_done  out  1  one-cycle pulse after the last packet of a frame completes.
frame_cnt  out  16  completed-frame counter.
timeout_err  out  1  one-cycle pulse on a WAIT_DONE timeout.

Behaviour:
- Clock: gmii_tx_clk only. Reset: rst is asynchronous and active-high.
- Reset values: all outputs 0, tx_byte_num = (2+PKT_WORDS)*4, state IDLE, pkt_idx 0, frame_cnt 0.
- Header word0 = {16'hA55A, frame_cnt}. Header word1 = {pkt_idx[15:0], PKT_WORDS[15:0]}.
- IDLE: if enable, go to WAIT_FRAME.
- WAIT_FRAME: on frame_start, set pkt_idx=0 and go to WAIT_DATA. If enable falls, go to IDLE.
- WAIT_DATA: if fifo_rd_cnt >= PKT_WORDS, go to START. No timeout applies here.
- START: drive tx_start_en=1 for exactly one cycle, clear word_cnt, go to SEND.
- SEND, per tx_req cycle:
  - word_cnt 0 loads word0 into tx_data.
  - word_cnt 1 loads word1.
  - word_cnt 2..PKT_WORDS+1 loads fifo_dout, with fifo_rd_en=1 combinationally in the same cycle.
  - word_cnt increments on each tx_req. After word PKT_WORDS+1 is issued, go to WAIT_DONE.
  - tx_data is registered and updates only on tx_req cycles.
- Extra tx_req in WAIT_DONE: tx_data=0, no FIFO pop.
- WAIT_DONE:
  - On udp_tx_done, increment pkt_idx.
  - If pkt_idx was PKTS_PER_FRAME-1: set pkt_idx=0, increment frame_cnt (wraps at 16 bits), pulse frame_done, go to GAP with last=1.
  - Timeout counter reaching TIMEOUT_CYCLES: pulse timeout_err, discard the remaining frame (pkt_idx=0), go to GAP with last=1.
- GAP: count IFG_CYCLES.
  - last=1: go to WAIT_FRAME if enable, else IDLE.
  - Otherwise: go to WAIT_DATA.
- enable falling mid-frame: the current packet completes; at GAP exit go to IDLE and abandon the frame. The FIFO is not flushed; the upstream block owns FIFO reset.
- frame_start outside WAIT_FRAME is ignored. No resync occurs mid-frame.
- fifo_rd_en is never asserted outside SEND payload words, which guarantees at most PKT_WORDS pops per packet.
- Async rst mid-packet: return immediately to reset values; udp_top is reset by the same system reset.

Decomposition:
- Shared package udp_img_pkg holds:
  - header magic 16'hA55A
  - state encoding (IDLE, WAIT_FRAME, WAIT_DATA, START, SEND, WAIT_DONE, GAP)
  - HDR_WORDS=2
  - a function computing the byte count
- One natural sub-module: udp_img_hdr_mux, the registered tx_data mux plus word counter. Everything else stays in one FSM module.

Test Plan:
- PKT_WORDS=4, PKTS_PER_FRAME=2, FIFO preloaded with 1..8, frame_start, model udp_top request timing:
  - tx_byte_num=24, two tx_start_en pulses.
  - Packet 0 carries A55A0000, 00000004, 1, 2, 3, 4.
  - Packet 1 carries A55A0000, 00010004, 5, 6, 7, 8.
  - frame_done pulses once, then frame_cnt=1.
- fifo_rd_cnt held at 3 with PKT_WORDS=4 -> no tx_start_en. Raising the count to 4 -> tx_start_en within 2 cycles.
- udp_tx_done withheld with TIMEOUT_CYCLES=100:
  - timeout_err pulses at 100 cycles in WAIT_DONE.
  - FSM returns to WAIT_FRAME after IFG_CYCLES.
  - frame_cnt is unchanged.
- enable deasserted during packet 0 of 2:
  - Packet 0 completes with exactly 4 pops.
  - No second tx_start_en; state ends in IDLE and busy=0.
- Gap check: consecutive tx_start_en pulses separated by at least IFG_CYCLES+1 cycles after udp_tx_done. An extra tx_req after the last word yields tx_data=0 and no pop.
- rst asserted mid-SEND -> all outputs 0 immediately (asynchronous); after release, a fresh frame_start sends header pkt_idx=0.
